// File: rtl/switch_pkg.sv
// Shared definitions for the switch port receive path: packet header layout,
// error bit positions, the beat layout carried through the skid and the FSM states.
package switch_pkg;

  localparam int DW = 8;

  localparam int IDX_DA  = 0;
  localparam int IDX_SA  = 1;
  localparam int IDX_LEN = 2;

  localparam int ERR_FCS   = 0;
  localparam int ERR_DA    = 1;
  localparam int ERR_TRUNC = 2;
  localparam int ERR_W     = 3;

  // Beat = {data, sop, eop, err}; data sits above BEAT_SOP.
  localparam int BEAT_EOP = 3;
  localparam int BEAT_SOP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    FCS  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/switch_rx_skid.sv
// Two-entry FIFO between byte capture and the output register. tag_or is OR-ed into
// the newest entry so a truncation can mark the last queued byte as end of packet.
module switch_rx_skid #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  input  logic [W-1:0] tag_or,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         tail;

  assign tail = ~wr_ptr;
  // With a single entry the head is also the tail, so a retag must show on the pop path.
  assign dout = mem[rd_ptr] | ((occ == 2'd1) ? tag_or : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
    else if (occ != 2'd0)
      mem[tail] <= mem[tail] | tag_or;
  end

endmodule

// File: rtl/switch_port_rx.sv
// Reading end of one switch output port: issues credit-limited reads, frames the
// returned bytes (DA, SA, LEN, payload, FCS) and forwards them with sop/eop/error tags.
module switch_port_rx #(
  parameter int DW      = switch_pkg::DW,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  output logic             read,
  input  logic [DW-1:0]    port_data,
  input  logic [DW-1:0]    cfg_addr,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  import switch_pkg::*;

  localparam int BW = DW + BEAT_SOP + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  rx_state_e         state, state_n;
  logic [1:0]        hdr_idx, hdr_idx_n;
  logic [DW-1:0]     len_cnt, len_cnt_n;
  logic [DW-1:0]     fcs_acc, fcs_acc_n;
  logic              da_err, da_err_n;
  logic [IW-1:0]     idle_cnt, idle_cnt_n;
  logic              cap_sop, cap_eop, trunc;
  logic [ERR_W-1:0]  cap_err, trunc_err;
  logic              vld_p0;
  logic [BW-1:0]     beat_p0, trunc_beat, new_beat, tag_or, skid_dout;
  logic              new_vld, push, pop, out_free, credit_ok;
  logic [1:0]        occ, occ_n;
  logic              vld_p1;
  logic [BW-1:0]     out_beat_p1;

  // Stage p0: byte on port_data this cycle, tagged by the framing FSM.
  always_comb begin
    state_n    = state;
    hdr_idx_n  = hdr_idx;
    len_cnt_n  = len_cnt;
    fcs_acc_n  = fcs_acc;
    da_err_n   = da_err;
    idle_cnt_n = idle_cnt;
    cap_sop    = 1'b0;
    cap_eop    = 1'b0;
    cap_err    = '0;
    trunc      = 1'b0;
    if (vld_p0) begin
      idle_cnt_n = '0;
      fcs_acc_n  = fcs_acc ^ port_data;
      case (state)
        IDLE: begin
          cap_sop   = 1'b1;
          fcs_acc_n = port_data;
          da_err_n  = (port_data != cfg_addr);
          hdr_idx_n = 2'(IDX_SA);
          state_n   = HDR;
        end
        HDR: begin
          hdr_idx_n = hdr_idx + 2'd1;
          if (hdr_idx == 2'(IDX_LEN)) begin
            len_cnt_n = port_data;
            state_n   = (port_data == '0) ? FCS : PAY;
          end
        end
        PAY: begin
          len_cnt_n = len_cnt - DW'(1);
          if (len_cnt == DW'(1)) state_n = FCS;
        end
        FCS: begin
          cap_eop          = 1'b1;
          cap_err[ERR_FCS] = (fcs_acc != port_data);
          cap_err[ERR_DA]  = da_err;
          state_n          = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && !ready) begin
      if (idle_cnt == IW'(TIMEOUT - 1)) begin
        trunc      = 1'b1;
        idle_cnt_n = '0;
        state_n    = IDLE;
      end else begin
        idle_cnt_n = idle_cnt + IW'(1);
      end
    end
  end

  always_comb begin
    trunc_err            = '0;
    trunc_err[ERR_TRUNC] = 1'b1;
    trunc_err[ERR_DA]    = da_err;
  end

  assign beat_p0    = {port_data, cap_sop, cap_eop, cap_err};
  assign trunc_beat = {{DW{1'b0}}, 1'b0, 1'b1, trunc_err};
  // A truncation retags the newest queued byte; with nothing queued a zero byte carries the eop.
  assign tag_or     = (trunc && occ != 2'd0) ? trunc_beat : '0;
  assign new_vld    = vld_p0 || (trunc && occ == 2'd0);
  assign new_beat   = vld_p0 ? beat_p0 : trunc_beat;

  assign out_free = !vld_p1 || out_ready;
  assign pop      = out_free && (occ != 2'd0);
  assign push     = new_vld && (!out_free || occ != 2'd0);
  assign occ_n    = occ + {1'b0, push} - {1'b0, pop};
  // Room for this read plus the one already outstanding even if the output never drains.
  assign credit_ok = (occ_n == 2'd0) || ((occ_n == 2'd1) && !read);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hdr_idx  <= 2'(IDX_DA);
      da_err   <= 1'b0;
      idle_cnt <= '0;
      read     <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      state    <= state_n;
      hdr_idx  <= hdr_idx_n;
      da_err   <= da_err_n;
      idle_cnt <= idle_cnt_n;
      read     <= ready && credit_ok;
      vld_p0   <= read;
    end
  end

  always_ff @(posedge clk) begin
    len_cnt <= len_cnt_n;
    fcs_acc <= fcs_acc_n;
  end

  switch_rx_skid #(.W(BW)) u_skid (
    .clk    (clk),
    .rst    (reset),
    .push   (push),
    .din    (new_beat),
    .pop    (pop),
    .dout   (skid_dout),
    .tag_or (tag_or),
    .occ    (occ)
  );

  // Stage p1: output register, refilled from the skid head or straight from p0.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      out_beat_p1 <= '0;
    end else if (out_free) begin
      if (occ != 2'd0) begin
        vld_p1      <= 1'b1;
        out_beat_p1 <= skid_dout;
      end else if (new_vld) begin
        vld_p1      <= 1'b1;
        out_beat_p1 <= new_beat;
      end else begin
        vld_p1      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (vld_p1 && out_ready && out_beat_p1[BEAT_EOP]) begin
      if (out_beat_p1[ERR_W-1:0] != '0) err_cnt <= err_cnt + CNT_W'(1);
      else                              pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = out_beat_p1[BW-1:BEAT_SOP+1];
  assign out_sop   = out_beat_p1[BEAT_SOP];
  assign out_eop   = out_beat_p1[BEAT_EOP];
  assign out_err   = out_beat_p1[ERR_W-1:0];

endmodule

// File: tb/tb_switch_port_rx.sv
// Directed bench for switch_port_rx: a switch-port model answers reads, a consumer
// drives out_ready, and every accepted beat is compared with hand-computed values.
module tb_switch_port_rx;
  import switch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ready, read;
  logic [7:0]  port_data, cfg_addr, out_data;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic [2:0]  out_err;
  logic [15:0] pkt_cnt, err_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  src_q[$];
  logic [12:0] exp_q[$];
  logic        pause = 1'b0;
  logic        rd_d = 1'b0;
  int          or_mode = 0;
  logic        tog = 1'b0;
  logic        stalled = 1'b0;
  logic [12:0] held = '0;
  int          outstanding = 0;

  always #5 clk = ~clk;

  switch_port_rx #(.DW(8), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .read      (read),
    .port_data (port_data),
    .cfg_addr  (cfg_addr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_err   (out_err),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: port model, consumer and checks all act on the falling edge.
  task automatic cycle();
    logic [12:0] b;
    @(negedge clk);
    if (rd_d) begin
      if (src_q.size() > 0) port_data = src_q.pop_front();
      else                  port_data = 8'h00;
      outstanding++;
    end
    rd_d  = read;
    ready = !pause && (src_q.size() > (read ? 1 : 0));
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       begin tog = ~tog; out_ready = tog; end
      default: out_ready = 1'b0;
    endcase
    b = {out_data, out_sop, out_eop, out_err};
    if (stalled) check("stable", 32'(b), 32'(held));
    if (out_valid && out_ready) begin
      outstanding--;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL extra_byte observed=%h expected=none", b);
      end
      if (exp_q.size() > 0) check("beat", 32'(b), 32'(exp_q.pop_front()));
    end
    check("outstanding_le3", 32'(outstanding <= 3), 32'(1));
    stalled = out_valid && !out_ready;
    held    = b;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic feed(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic sop, input logic eop,
                             input logic [2:0] err);
    exp_q.push_back({d, sop, eop, err});
  endtask

  task automatic send(input logic [127:0] v, input int n, input logic [2:0] err);
    feed(v, n);
    for (int i = 0; i < n; i++)
      expect_beat(v[8*(n-1-i) +: 8], i == 0, i == n - 1, (i == n - 1) ? err : 3'b000);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s_timeout observed=%0d pending expected=0", tag, exp_q.size());
    end
    exp_q.delete();
    run(2);
  endtask

  initial begin
    reset     = 1'b1;
    ready     = 1'b0;
    port_data = 8'h00;
    cfg_addr  = 8'h01;
    out_ready = 1'b0;
    or_mode   = 2;
    run(3);
    check("rst_read",      32'(read),      32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_sop",   32'(out_sop),   32'(0));
    check("rst_out_eop",   32'(out_eop),   32'(0));
    check("rst_out_err",   32'(out_err),   32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_pkt_cnt",   32'(pkt_cnt),   32'(0));
    check("rst_err_cnt",   32'(err_cnt),   32'(0));
    reset   = 1'b0;
    or_mode = 0;
    run(2);

    // Good packet, with latency checks on the first byte.
    send({8'h01, 8'h05, 8'h02, 8'hAA, 8'h55, 8'hF9}, 6, 3'b000);
    cycle();
    cycle();
    check("ready_to_read", 32'(read), 32'(1));
    cycle();
    check("valid_not_yet", 32'(out_valid), 32'(0));
    cycle();
    check("read_to_valid", 32'(out_valid), 32'(1));
    check("first_sop", 32'(out_sop), 32'(1));
    drain("pkt_good", 60);
    check("pkt_cnt_1", 32'(pkt_cnt), 32'(1));
    check("err_cnt_0", 32'(err_cnt), 32'(0));

    send({8'h01, 8'h05, 8'h02, 8'hAA, 8'h55, 8'h00}, 6, 3'b001);
    drain("pkt_fcs", 60);
    check("fcs_err_cnt", 32'(err_cnt), 32'(1));
    check("fcs_pkt_cnt", 32'(pkt_cnt), 32'(1));

    send({8'h02, 8'h05, 8'h02, 8'hAA, 8'h55, 8'hFA}, 6, 3'b010);
    drain("pkt_da", 60);
    check("da_err_cnt", 32'(err_cnt), 32'(2));

    send({8'h01, 8'h05, 8'h00, 8'h04}, 4, 3'b000);
    drain("pkt_len0", 60);
    check("len0_pkt_cnt", 32'(pkt_cnt), 32'(2));

    // Toggling consumer plus a short ready pause that must not truncate.
    or_mode = 1;
    send({8'h01, 8'h05, 8'h06, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h72}, 10, 3'b000);
    run(6);
    pause = 1'b1;
    run(10);
    pause = 1'b0;
    drain("pkt_toggle", 120);
    or_mode = 0;
    check("toggle_pkt_cnt", 32'(pkt_cnt), 32'(3));
    check("toggle_err_cnt", 32'(err_cnt), 32'(2));

    // Truncated after the third payload byte; everything already sent, so a zero eop byte.
    feed({8'h01, 8'h05, 8'h08, 8'h11, 8'h22, 8'h33}, 6);
    expect_beat(8'h01, 1'b1, 1'b0, 3'b000);
    expect_beat(8'h05, 1'b0, 1'b0, 3'b000);
    expect_beat(8'h08, 1'b0, 1'b0, 3'b000);
    expect_beat(8'h11, 1'b0, 1'b0, 3'b000);
    expect_beat(8'h22, 1'b0, 1'b0, 3'b000);
    expect_beat(8'h33, 1'b0, 1'b0, 3'b000);
    expect_beat(8'h00, 1'b0, 1'b1, 3'b100);
    drain("pkt_trunc", 120);
    check("trunc_err_cnt", 32'(err_cnt), 32'(3));
    check("trunc_fsm_idle", 32'(dut.state), 32'(IDLE));

    send({8'h01, 8'h05, 8'h02, 8'hAA, 8'h55, 8'hF9}, 6, 3'b000);
    drain("pkt_after_trunc", 60);
    check("after_trunc_pkt_cnt", 32'(pkt_cnt), 32'(4));

    // Truncation while stalled: the newest queued byte is retagged.
    or_mode = 2;
    feed({8'h01, 8'h05, 8'h08}, 3);
    expect_beat(8'h01, 1'b1, 1'b0, 3'b000);
    expect_beat(8'h05, 1'b0, 1'b0, 3'b000);
    expect_beat(8'h08, 1'b0, 1'b1, 3'b100);
    run(40);
    or_mode = 0;
    drain("pkt_trunc_stall", 60);
    check("stall_trunc_err_cnt", 32'(err_cnt), 32'(4));

    send({8'h01, 8'h05, 8'h00, 8'h04}, 4, 3'b000);
    drain("pkt_final", 60);
    check("final_pkt_cnt", 32'(pkt_cnt), 32'(5));
    check("final_err_cnt", 32'(err_cnt), 32'(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
